nbit_stored_program_cpu: RTL and testbench

Parametrised successor to the team's 2-bit stored-program computer. It keeps the INC / JNO / HLT instruction model. It adds an N-bit accumulator, a 2^ADDR_W-word writable program memory, a CLR instruction, a start/halt/restart control FSM, and a single-step debug mode. It sits at the top of the teaching datapath: a testbench or front panel loads a program, pulses start, and observes PC, R and RS.

---
 rtl/nbit_stored_program_cpu.sv | 116 +++++++++++
 tb/tb_nbit_stored_program_cpu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nbit_stored_program_cpu.sv
// Parametrised stored-program CPU: INC / JNO / HLT / CLR on an N-bit accumulator,
// with a writable program memory, start/halt/restart control and single-step mode.
module nbit_stored_program_cpu #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [ADDR_W+1:0] prog_data,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] r,
    output logic              rs,
    output logic              running,
    output logic              halted
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_JNO = 2'b01;
    localparam logic [1:0] OP_HLT = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W+1:0] mem [DEPTH];
    logic [ADDR_W+1:0] instr;
    logic [1:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic              exec;
    logic [DATA_W:0]   inc_sum;
    logic [ADDR_W-1:0] pc_inc;

    assign instr   = mem[pc];
    assign opcode  = instr[ADDR_W+1:ADDR_W];
    assign operand = instr[ADDR_W-1:0];
    assign exec    = (state == S_RUN) && (!step_mode || step);
    assign inc_sum = {1'b0, r} + (DATA_W+1)'(1);
    assign pc_inc  = pc + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (exec && opcode == OP_HLT) state_next = S_HALT;
            S_HALT:  if (start) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        running = (state == S_RUN);
        halted  = (state == S_HALT);
    end

    // Program memory survives reset; it is only writable while the core is stopped.
    always_ff @(posedge clk) begin
        if (prog_we && !reset && state != S_RUN) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
            r  <= '0;
            rs <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) pc <= '0;
                end
                S_RUN: begin
                    if (exec) begin
                        case (opcode)
                            OP_INC: begin
                                r  <= inc_sum[DATA_W-1:0];
                                rs <= inc_sum[DATA_W];
                                pc <= pc_inc;
                            end
                            OP_JNO: pc <= rs ? pc_inc : operand;
                            OP_CLR: begin
                                r  <= '0;
                                rs <= 1'b0;
                                pc <= pc_inc;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nbit_stored_program_cpu.sv
// Scoreboard bench: two CPUs (DATA_W=2 and DATA_W=4, both ADDR_W=2) share stimulus;
// expected states are queued by the stimulus and compared by a negedge monitor.
module tb_nbit_stored_program_cpu;

    logic       clk;
    logic       reset;
    logic       start;
    logic       step_mode;
    logic       step;
    logic       prog_we;
    logic [1:0] prog_addr;
    logic [3:0] prog_data;

    logic [1:0] pc_a;
    logic [1:0] r_a;
    logic       rs_a;
    logic       running_a;
    logic       halted_a;

    logic [1:0] pc_b;
    logic [3:0] r_b;
    logic       rs_b;
    logic       running_b;
    logic       halted_b;

    localparam logic [3:0] INC = 4'b0000;
    localparam logic [3:0] JNO0 = 4'b0100;
    localparam logic [3:0] HLT = 4'b1000;
    localparam logic [3:0] CLR = 4'b1100;

    typedef struct {
        string      name;
        bit         sel;
        logic [1:0] pc;
        logic [3:0] r;
        logic       rs;
        logic       run;
        logic       halt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    nbit_stored_program_cpu #(.DATA_W(2), .ADDR_W(2)) dut_a (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .pc(pc_a), .r(r_a), .rs(rs_a), .running(running_a), .halted(halted_a)
    );

    nbit_stored_program_cpu #(.DATA_W(4), .ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .pc(pc_b), .r(r_b), .rs(rs_b), .running(running_b), .halted(halted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the stimulus only queues expectations, this process owns the comparisons.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t       e;
            logic [1:0] act_pc;
            logic [3:0] act_r;
            logic       act_rs;
            logic       act_run;
            logic       act_halt;
            e = exp_q.pop_front();
            if (e.sel) begin
                act_pc = pc_b; act_r = r_b; act_rs = rs_b;
                act_run = running_b; act_halt = halted_b;
            end else begin
                act_pc = pc_a; act_r = {2'b00, r_a}; act_rs = rs_a;
                act_run = running_a; act_halt = halted_a;
            end
            checks++;
            if (act_pc !== e.pc || act_r !== e.r || act_rs !== e.rs ||
                act_run !== e.run || act_halt !== e.halt) begin
                errors++;
                $display("[TB] FAIL %s: got pc=%0d r=%0d rs=%0b run=%0b halt=%0b, expected pc=%0d r=%0d rs=%0b run=%0b halt=%0b",
                         e.name, act_pc, act_r, act_rs, act_run, act_halt,
                         e.pc, e.r, e.rs, e.run, e.halt);
            end
        end
    end

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic writeMem(input logic [1:0] addr, input logic [3:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        applyStimulus(1);
        prog_we   = 1'b0;
    endtask

    task automatic checkOutput(input string name, input bit sel, input logic [1:0] pc,
                               input logic [3:0] r, input logic rs,
                               input logic run, input logic halt);
        exp_t e;
        e.name = name; e.sel = sel; e.pc = pc; e.r = r;
        e.rs = rs; e.run = run; e.halt = halt;
        exp_q.push_back(e);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation timed out");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        applyStimulus(2);
        reset = 1'b0;
        checkOutput("reset_a", 0, 2'd0, 4'd0, 0, 0, 0);
        checkOutput("reset_b", 1, 2'd0, 4'd0, 0, 0, 0);

        // Counting loop: INC / JNO 0 / HLT on the 2-bit accumulator.
        writeMem(2'd0, INC);
        writeMem(2'd1, JNO0);
        writeMem(2'd2, HLT);
        writeMem(2'd3, HLT);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("launch", 0, 2'd0, 4'd0, 0, 1, 0);
        applyStimulus(1);
        checkOutput("first_inc", 0, 2'd1, 4'd1, 0, 1, 0);
        applyStimulus(7);
        checkOutput("jno_fallthrough", 0, 2'd2, 4'd0, 1, 1, 0);
        applyStimulus(1);
        checkOutput("halt_after_9", 0, 2'd2, 4'd0, 1, 0, 1);
        applyStimulus(2);
        checkOutput("halt_holds", 0, 2'd2, 4'd0, 1, 0, 1);

        // CLR at address 0, restart from HALT: endless CLR/JNO loop.
        writeMem(2'd0, CLR);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("restart_keeps_rs", 0, 2'd0, 4'd0, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            checkOutput("clr_loop", 0, (i % 2 == 0) ? 2'd1 : 2'd0, 4'd0, 0, 1, 0);
        end

        // INC-only program on the 4-bit accumulator: pc and r wrap.
        doReset();
        checkOutput("reset_b2", 1, 2'd0, 4'd0, 0, 0, 0);
        for (int a = 0; a < 4; a++) writeMem(2'(a), INC);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("launch_b", 1, 2'd0, 4'd0, 0, 1, 0);
        applyStimulus(3);
        checkOutput("inc_3", 1, 2'd3, 4'd3, 0, 1, 0);
        applyStimulus(1);
        checkOutput("pc_wrap", 1, 2'd0, 4'd4, 0, 1, 0);
        start = 1'b1;
        applyStimulus(2);
        start = 1'b0;
        checkOutput("start_ignored_in_run", 1, 2'd2, 4'd6, 0, 1, 0);
        applyStimulus(9);
        checkOutput("inc_15", 1, 2'd3, 4'd15, 0, 1, 0);
        applyStimulus(1);
        checkOutput("inc_16_carry", 1, 2'd0, 4'd0, 1, 1, 0);
        applyStimulus(1);
        checkOutput("inc_17", 1, 2'd1, 4'd1, 0, 1, 0);

        // Single-step mode.
        step_mode = 1'b1;
        applyStimulus(5);
        checkOutput("step_frozen", 1, 2'd1, 4'd1, 0, 1, 0);
        step = 1'b1;
        applyStimulus(1);
        step = 1'b0;
        checkOutput("single_step", 1, 2'd2, 4'd2, 0, 1, 0);
        applyStimulus(2);
        checkOutput("step_frozen_again", 1, 2'd2, 4'd2, 0, 1, 0);
        step_mode = 1'b0;

        // Writes during RUN are ignored; reset mid-RUN commits nothing.
        doReset();
        writeMem(2'd0, INC);
        writeMem(2'd1, INC);
        writeMem(2'd2, HLT);
        writeMem(2'd3, INC);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        prog_we = 1'b1; prog_addr = 2'd2; prog_data = INC;
        applyStimulus(1);
        prog_we = 1'b0;
        checkOutput("run_write_inc1", 1, 2'd1, 4'd1, 0, 1, 0);
        applyStimulus(2);
        checkOutput("run_write_ignored", 1, 2'd2, 4'd2, 0, 0, 1);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("restart_r2", 1, 2'd0, 4'd2, 0, 1, 0);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("reset_mid_run", 1, 2'd0, 4'd0, 0, 0, 0);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(3);
        checkOutput("mem_retained", 1, 2'd2, 4'd2, 0, 0, 1);

        // Write HLT to address 0 in the same cycle as start.
        doReset();
        start = 1'b1; prog_we = 1'b1; prog_addr = 2'd0; prog_data = HLT;
        applyStimulus(1);
        start = 1'b0; prog_we = 1'b0;
        checkOutput("write_start_launch", 0, 2'd0, 4'd0, 0, 1, 0);
        applyStimulus(1);
        checkOutput("write_start_halt_a", 0, 2'd0, 4'd0, 0, 0, 1);
        checkOutput("write_start_halt_b", 1, 2'd0, 4'd0, 0, 0, 1);

        applyStimulus(2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
